tx_stuff_ctrl: RTL

TX_STUFF_CTRL -- requirements
Module: tx_stuff_ctrl

---
 rtl/usb_tx_pkg.sv | 26 ++
 rtl/tx_bit_serializer.sv | 33 +++
 rtl/tx_stuff_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit path: controller states, CRC mode
// encodings and CRC lengths.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SYNC  = 3'd2,
        ST_DATA  = 3'd3,
        ST_CRC   = 3'd4,
        ST_GAP   = 3'd5
    } tx_state_e;

    localparam logic [1:0] CRC_NONE   = 2'b00;
    localparam logic [1:0] CRC_MODE5  = 2'b01;
    localparam logic [1:0] CRC_MODE16 = 2'b10;

    localparam int CRC5_LEN  = 5;
    localparam int CRC16_LEN = 16;

    // Index of the final CRC shift cycle for a mode that carries a CRC.
    function automatic logic [4:0] crc_last_idx(input logic [1:0] mode);
        return (mode == CRC_MODE16) ? 5'(CRC16_LEN - 1) : 5'(CRC5_LEN - 1);
    endfunction

endpackage

// File: rtl/tx_bit_serializer.sv
// Byte-wide LSB-first serializer with a 3-bit position counter; the shift
// freezes while halt is high, and a load always takes priority.
module tx_bit_serializer (
    input  logic       gclk,
    input  logic       reset_l,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       shift_en,
    input  logic       halt,
    output logic       bit_out,
    output logic       last_bit
);

    logic [7:0] shreg;
    logic [2:0] bit_cnt;

    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= load_byte;
            bit_cnt <= '0;
        end else if (shift_en && !halt) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    assign bit_out  = shreg[0];
    assign last_bit = (bit_cnt == 3'd7);

endmodule

// File: rtl/tx_stuff_ctrl.sv
// Transmit controller feeding the bit stuffer: clear, SYNC, payload bytes,
// optional CRC hand-off and an end-of-packet gap.
module tx_stuff_ctrl
    import usb_tx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         EOP_GAP   = 3
) (
    input  logic       gclk,
    input  logic       reset_l,
    input  logic       tx_start,
    input  logic [1:0] pkt_crc,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       halt_tx_shift,
    output logic       start_bit_stuff,
    output logic       stuff_din,
    output logic       shift_tx_crc5,
    output logic       shift_tx_crc16,
    output logic       cs1_l,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [2:0] dbg_state
);

    localparam logic [4:0] GAP_LAST = 5'(EOP_GAP - 1);

    tx_state_e  state;
    tx_state_e  state_nxt;
    logic [1:0] crc_mode;
    logic       last_byte;
    logic [4:0] cnt;
    logic       err_pulse;
    logic       ser_bit;
    logic       ser_last;
    logic       shifting;
    logic       crc_on;
    logic       accept;
    logic       underrun;

    assign shifting = (state == ST_SYNC) || (state == ST_DATA);
    assign crc_on   = (crc_mode == CRC_MODE5) || (crc_mode == CRC_MODE16);

    // Byte handshake: a byte moves when tx_ready && tx_valid in the same cycle.
    // tx_ready is offered only on the final bit of SYNC or of a non-last byte,
    // and never while halted; tx_valid low at that moment is an underrun.
    assign tx_ready = !halt_tx_shift && ser_last &&
                      ((state == ST_SYNC) || (state == ST_DATA && !last_byte));
    assign accept   = tx_ready && tx_valid;
    assign underrun = tx_ready && !tx_valid;

    tx_bit_serializer u_ser (
        .gclk      (gclk),
        .reset_l   (reset_l),
        .load      ((state == ST_CLEAR) || accept),
        .load_byte ((state == ST_CLEAR) ? SYNC_BYTE : tx_byte),
        .shift_en  (shifting),
        .halt      (halt_tx_shift),
        .bit_out   (ser_bit),
        .last_bit  (ser_last)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (tx_start) state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = ST_SYNC;
            ST_SYNC:  if (tx_ready) state_nxt = tx_valid ? ST_DATA : ST_IDLE;
            ST_DATA: begin
                if (tx_ready)
                    state_nxt = tx_valid ? ST_DATA : ST_IDLE;
                else if (!halt_tx_shift && ser_last && last_byte)
                    state_nxt = crc_on ? ST_CRC : ST_GAP;
            end
            ST_CRC:   if (!halt_tx_shift && cnt == crc_last_idx(crc_mode)) state_nxt = ST_GAP;
            ST_GAP:   if (cnt == GAP_LAST) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            state     <= ST_IDLE;
            crc_mode  <= CRC_NONE;
            last_byte <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            err_pulse <= underrun;
            if (state == ST_IDLE && tx_start) crc_mode <= pkt_crc;
            if (state == ST_CLEAR) last_byte <= 1'b0;
            else if (accept)       last_byte <= tx_last;
        end
    end

    // One counter serves both CRC length and gap length; it restarts on every state change.
    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l)
            cnt <= '0;
        else if (state_nxt != state)
            cnt <= '0;
        else if ((state == ST_CRC && !halt_tx_shift) || state == ST_GAP)
            cnt <= cnt + 5'd1;
    end

    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l)
            stuff_din <= 1'b0;
        else if (!halt_tx_shift)
            stuff_din <= shifting && ser_bit;
    end

    assign start_bit_stuff = shifting || (state == ST_CRC);
    assign shift_tx_crc5   = (state == ST_CRC) && !halt_tx_shift && (crc_mode == CRC_MODE5);
    assign shift_tx_crc16  = (state == ST_CRC) && !halt_tx_shift && (crc_mode == CRC_MODE16);
    assign cs1_l           = !((state == ST_CLEAR) || err_pulse);
    assign tx_busy         = (state != ST_IDLE);
    assign tx_done         = (state == ST_GAP) && (cnt == GAP_LAST);
    assign tx_err          = err_pulse;
    assign dbg_state       = state;

endmodule
